// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC sequencer for the single-cycle MIPS core.
// It also runs the boot/run/halt control and counts retired instructions.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter logic [5:0]  JUMP_OPCODE = 6'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        branch_taken,
    input  logic [31:0] branch_imm,
    input  logic        stall,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] instr_count
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  opcode;

    assign opcode   = instruction[31:26];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    cnt_d = cnt_q + 32'd1;
                    // Halt is retired but the PC parks on it until resume.
                    if (opcode == HALT_OPCODE)
                        state_d = ST_HALT;
                    else if (opcode == JUMP_OPCODE)
                        pc_d = {pc_plus4[31:28], instruction[25:0], 2'b00};
                    else if (branch_taken)
                        pc_d = pc_plus4 + (branch_imm << 2);
                    else
                        pc_d = pc_plus4;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    pc_d    = pc_plus4;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc          = pc_q;
    assign instr_count = cnt_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_valid = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, branch, jump, stall, halt/resume,
// PC wrap (second instance with a high reset PC) and asynchronous reset.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        branch_taken;
    logic [31:0] branch_imm;
    logic        stall;
    logic        resume;
    logic [31:0] pc, pc_plus4, instr_count;
    logic        fetch_valid, halted;
    logic [31:0] w_pc, w_pc_plus4, w_instr_count;
    logic        w_fetch_valid, w_halted;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .stall(stall), .resume(resume), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .halted(halted), .instr_count(instr_count)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(rst_n), .instruction(instruction),
        .branch_taken(branch_taken), .branch_imm(branch_imm),
        .stall(stall), .resume(resume), .pc(w_pc), .pc_plus4(w_pc_plus4),
        .fetch_valid(w_fetch_valid), .halted(w_halted), .instr_count(w_instr_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks pc, instr_count, fetch_valid and halted of the main instance.
    task automatic expect_main(input string name, input logic [31:0] epc,
                               input logic [31:0] ecnt, input logic efv, input logic ehalt);
        checks++;
        if (pc !== epc || instr_count !== ecnt || fetch_valid !== efv || halted !== ehalt) begin
            errors++;
            $display("FAIL %s: got pc=%h cnt=%0d fv=%b halted=%b, want pc=%h cnt=%0d fv=%b halted=%b",
                     name, pc, instr_count, fetch_valid, halted, epc, ecnt, efv, ehalt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instruction = 32'h0; branch_taken = 1'b0; branch_imm = 32'h0;
        stall = 1'b0; resume = 1'b0;
        step(); step();
        expect_main("reset_state", 32'h0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (pc_plus4 !== 32'h4 || w_pc !== 32'hFFFF_FFF8 || w_pc_plus4 !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL reset_plus4: got pc_plus4=%h w_pc=%h w_pc_plus4=%h, want 00000004 fffffff8 fffffffc",
                     pc_plus4, w_pc, w_pc_plus4);
        end
        rst_n = 1'b1;
        #1;
        expect_main("boot_idle", 32'h0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_boot_and_wrap();
        logic [31:0] wexp [0:3];
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0; wexp[3] = 32'h4;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_main("boot_seq", 32'(i * 4), 32'(i), 1'b1, 1'b0);
            checks++;
            if (w_pc !== wexp[i]) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: got %h want %h", i, w_pc, wexp[i]);
            end
        end
        step();  // pc=0x10, count 4
        expect_main("reach_10", 32'h10, 32'd4, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_imm = 32'hFFFF_FFFE;
        step();
        expect_main("branch_back", 32'h0C, 32'd5, 1'b1, 1'b0);
        branch_taken = 1'b0;
        step();
        expect_main("branch_seq", 32'h10, 32'd6, 1'b1, 1'b0);
        branch_taken = 1'b1; branch_imm = 32'd3;
        step();
        expect_main("branch_fwd", 32'h20, 32'd7, 1'b1, 1'b0);
        branch_taken = 1'b0;
    endtask

    task automatic test_stall();
        instruction = 32'h0800_0002;  // jump to 0x8
        step();
        expect_main("jump_to_8", 32'h8, 32'd8, 1'b1, 1'b0);
        instruction = 32'h0; stall = 1'b1;
        #1;
        expect_main("stall_fv", 32'h8, 32'd8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_main("stall_hold", 32'h8, 32'd8, 1'b0, 1'b0);
        end
        stall = 1'b0;
        #1;
        expect_main("unstall_fv", 32'h8, 32'd8, 1'b1, 1'b0);
        step();
        expect_main("unstall_seq", 32'hC, 32'd9, 1'b1, 1'b0);
    endtask

    task automatic test_jump();
        branch_taken = 1'b1; branch_imm = 32'h03FF_FFFD;  // 0x10 + 0x0FFFFFF4
        step();
        expect_main("branch_far", 32'h1000_0004, 32'd10, 1'b1, 1'b0);
        branch_taken = 1'b0; instruction = 32'h0800_0040;
        step();
        expect_main("jump", 32'h1000_0100, 32'd11, 1'b1, 1'b0);
        instruction = 32'h0800_0001;
        step();
        expect_main("jump_back", 32'h1000_0004, 32'd12, 1'b1, 1'b0);
        instruction = 32'h0800_0040; branch_taken = 1'b1; branch_imm = 32'd5;
        step();
        expect_main("jump_over_branch", 32'h1000_0100, 32'd13, 1'b1, 1'b0);
        instruction = 32'h0; branch_imm = 32'hFBFF_FFC4;  // 0x10000104 -> 0x14
        step();
        expect_main("branch_to_14", 32'h14, 32'd14, 1'b1, 1'b0);
        branch_taken = 1'b0; branch_imm = 32'h0;
    endtask

    task automatic test_halt_resume();
        instruction = 32'hFC00_0000;
        step();
        expect_main("halt_enter", 32'h14, 32'd15, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            step();
            expect_main("halt_hold", 32'h14, 32'd15, 1'b0, 1'b1);
        end
        stall = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0; instruction = 32'h0;
        expect_main("resume", 32'h18, 32'd15, 1'b1, 1'b0);
        resume = 1'b1;  // ignored in RUN
        step();
        resume = 1'b0;
        expect_main("resume_in_run", 32'h1C, 32'd16, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        instruction = 32'hFC00_0000;
        step();
        expect_main("halt_again", 32'h1C, 32'd17, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        expect_main("async_reset", 32'h0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (w_pc !== 32'hFFFF_FFF8 || w_halted !== 1'b0 || w_instr_count !== 32'd0 || w_fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_w: got pc=%h halted=%b cnt=%0d fv=%b, want fffffff8 0 0 0",
                     w_pc, w_halted, w_instr_count, w_fetch_valid);
        end
        instruction = 32'h0;
        step();
        rst_n = 1'b1;
        #1;
        expect_main("reboot_idle", 32'h0, 32'd0, 1'b0, 1'b0);
        step();
        expect_main("reboot_run", 32'h0, 32'd0, 1'b1, 1'b0);
        step();
        expect_main("reboot_seq", 32'h4, 32'd1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_boot_and_wrap();
        test_branch();
        test_stall();
        test_jump();
        test_halt_resume();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and next-PC sequencer for the single-cycle MIPS core. It holds the architectural PC register, drives the instruction-memory read address, and picks the next PC each cycle: sequential, conditional branch, jump or hold. It also runs a small boot/run/halt state machine and counts retired instructions. It sits directly upstream of the core datapath: its `pc` output feeds instruction memory and the datapath PC input, and it consumes the fetched instruction, the branch decision and the sign-extended immediate back from that datapath.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `HALT_OPCODE`, default 6'h3F: opcode in instruction[31:26] that halts fetch.
- `JUMP_OPCODE`, default 6'h02: opcode decoded here as an absolute jump.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  asynchronous active-low reset.
- `instruction`  in  32  instruction currently fetched at `pc`.
- `branch_taken`  in  1  Branch AND Zero from the datapath for the current instruction.
- `branch_imm`  in  32  sign-extended 16-bit immediate of the current instruction.
- `stall`  in  1  hold PC and suppress retirement this cycle.
- `resume`  in  1  single-cycle pulse that leaves HALT.
- `pc`  out  32  registered program counter.
- `pc_plus4`  out  32  pc + 4, combinational.
- `fetch_valid`  out  1  current instruction is architecturally live.
- `halted`  out  1  state is HALT.
- `instr_count`  out  32  retired-instruction counter.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: fetch_valid=0 and pc is held. On the next edge the state goes to RUN unconditionally, with stall ignored. This gives one idle cycle so instruction memory settles after reset.
- RUN: fetch_valid = !stall. The next PC is chosen by this priority, highest first:
  - stall=1: pc is held and instr_count is held.
  - opcode == HALT_OPCODE: pc is held at the halt instruction, the state goes to HALT, and instr_count increments.
  - opcode == JUMP_OPCODE: pc <= {pc_plus4[31:28], instruction[25:0], 2'b00}.
  - branch_taken=1: pc <= pc_plus4 + (branch_imm << 2), 32-bit and wrapping.
  - Otherwise: pc <= pc_plus4.
- In RUN, every non-stalled edge increments instr_count by 1. The counter wraps from 32'hFFFF_FFFF to 0.
- Jump beats branch if both apply. Control must not produce both; the unit resolves the conflict anyway.
- HALT: halted=1, fetch_valid=0, pc and instr_count are held, and stall is ignored. resume=1 on an edge sets pc <= pc_plus4 and moves to RUN. The halt instruction is not re-executed.
- resume is ignored in BOOT and RUN.
- All PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC sequences to 32'h0000_0000.
- Branch and jump targets are always word-aligned by construction. No alignment check is performed.

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, fetch_valid=0, halted=0, instr_count=0, state=BOOT.
- Reset acts immediately on rst_n falling, at any state or mid-instruction. Release is sampled on the next rising edge.
- pc changes only on rising clk edges. It is stable for the whole cycle, giving the datapath a full cycle for fetch, decode and execute.
- Next-PC latency: the decision made in cycle N appears on pc in cycle N+1. There is no branch delay slot.
- First live fetch: the cycle after the first post-reset edge, i.e. the second cycle after release. That fetch is at RESET_PC.
- fetch_valid, halted and instr_count are registered or decoded from registered state. Only `fetch_valid` also depends on the `stall` input.
- Halt-to-resume: the resume edge moves pc to halt_addr+4 and sets halted=0 in the same cycle.

## Test plan
- Reset and boot: hold rst_n=0, then release with NOPs fed. Required: pc=0 and fetch_valid=0 for one cycle; then pc=0, 4, 8, 12 on successive cycles with instr_count=0, 1, 2, 3 alongside.
- Branch backwards: at pc=32'h10, set branch_taken=1 and branch_imm=32'hFFFF_FFFE. Required: next pc=32'h0C. With branch_imm=3 instead, required: next pc=32'h20.
- Jump: at pc=32'h1000_0004, feed instruction=32'h0800_0040. Required: next pc=32'h1000_0100. Also assert branch_taken the same cycle: the result must still be 32'h1000_0100.
- Stall: assert stall for 3 cycles at pc=32'h8. Required: pc stays 32'h8, fetch_valid=0 and instr_count is frozen; after release pc=32'hC.
- Halt and resume: feed 32'hFC00_0000 at pc=32'h14. Required: halted=1, pc holds 32'h14 for 5 cycles with stall toggling, and instr_count increments once. A resume pulse then gives pc=32'h18 and halted=0.
- Wrap and mid-op reset: with RESET_PC=32'hFFFF_FFF8, step sequentially. Required: pc=FFFF_FFF8, FFFF_FFFC, 0000_0000. Pulse rst_n low mid-cycle during HALT: pc, state and outputs must return to their reset values asynchronously.
